// File: rtl/inta_sequencer_if.sv
// Bus bundle between the PIC core/CPU side and the INTA sequencer.
// master drives requests and strobes; slave is the sequencer.
interface inta_sequencer_if;
  logic       irq_valid;
  logic [2:0] irq_level;
  logic       inta_n;
  logic [4:0] icw2_base;
  logic       eoi_strobe;
  logic       int_out;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] isr;
  logic [7:0] irr_clr;
  logic       busy;

  modport master (
    output irq_valid, irq_level, inta_n,
    output icw2_base, eoi_strobe,
    input  int_out, data_out, data_oe,
    input  isr, irr_clr, busy
  );

  modport slave (
    input  irq_valid, irq_level, inta_n,
    input  icw2_base, eoi_strobe,
    output int_out, data_out, data_oe,
    output isr, irr_clr, busy
  );
endinterface

// File: rtl/inta_sequencer.sv
// 8259A-style INTA handshake sequencer and In-Service Register.
// Define PIC_AEOI_EN for automatic EOI on the second INTA rise.
module inta_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  inta_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, REQ, ACK1, WAIT2, ACK2
  } state_t;

  localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   fall;
  logic                   rise;
  logic [7:0]             cnt;
  logic [2:0]             lvl;
  logic                   int_q;
  logic                   oe_q;
  logic [7:0]             dout_q;
  logic [7:0]             irr_q;
  logic [7:0]             isr_q;
  logic [7:0]             set_vec;
  logic [7:0]             aeoi_vec;
  logic [7:0]             isr_a;
  logic [7:0]             isr_nxt;
  logic                   done;
`ifdef PIC_AEOI_EN
  logic                   spur;
`endif

  assign fall = prev & ~sync[SYNC_STAGES-1];
  assign rise = ~prev & sync[SYNC_STAGES-1];

  // inta_n synchroniser plus edge-detect history, idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.inta_n};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  // ISR next value: AEOI first, then EOI on highest bit, then new set
  always_comb begin
    set_vec  = '0;
    aeoi_vec = '0;
    done     = 1'b0;
    if (state == REQ && fall && bus.irq_valid)
      set_vec[bus.irq_level] = 1'b1;
`ifdef PIC_AEOI_EN
    if (state == ACK2 && rise && !spur)
      aeoi_vec[lvl] = 1'b1;
`endif
    isr_a   = isr_q & ~aeoi_vec;
    isr_nxt = isr_a;
    if (bus.eoi_strobe) begin
      for (int i = 7; i >= 0; i--) begin
        if (!done && isr_a[i]) begin
          isr_nxt[i] = 1'b0;
          done       = 1'b1;
        end
      end
    end
    isr_nxt = isr_nxt | set_vec;
  end

  // handshake FSM with registered outputs and ISR state
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      int_q  <= 1'b0;
      oe_q   <= 1'b0;
      dout_q <= '0;
      irr_q  <= '0;
      isr_q  <= '0;
      cnt    <= '0;
      lvl    <= '0;
`ifdef PIC_AEOI_EN
      spur   <= 1'b0;
`endif
    end else begin
      isr_q <= isr_nxt;
      irr_q <= set_vec;
      unique case (state)
        IDLE: begin
          if (bus.irq_valid) begin
            state <= REQ;
            int_q <= 1'b1;
          end
        end
        REQ: begin
          if (fall) begin
            state <= ACK1;
            int_q <= 1'b0;
            lvl   <= bus.irq_valid ? bus.irq_level : 3'd7;
`ifdef PIC_AEOI_EN
            spur  <= ~bus.irq_valid;
`endif
          end
        end
        ACK1: begin
          if (rise) begin
            state <= WAIT2;
            cnt   <= '0;
          end
        end
        WAIT2: begin
          if (fall) begin
            state  <= ACK2;
            dout_q <= {bus.icw2_base, lvl};
            oe_q   <= 1'b1;
          end else if (cnt == TMO) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ACK2: begin
          if (rise) begin
            state <= IDLE;
            oe_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.int_out  = int_q;
  assign bus.data_out = dout_q;
  assign bus.data_oe  = oe_q;
  assign bus.isr      = isr_q;
  assign bus.irr_clr  = irr_q;
  assign bus.busy     = (state != IDLE);

endmodule
